seq_mag_comparator: RTL
=======================

Name: seq_mag_comparator

Overview:
- Parametrised, iterative magnitude comparator; the multi-cycle successor to the combinational 4-bit comparator built from 2-bit comparator slices.
- Compares two WIDTH-bit operands one 2-bit slice per clock, MSB slice first.
- Terminates early on the first unequal slice.
- Supports unsigned and two's-complement modes, with a start/busy/done handshake for sequencing by a controller.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- SLICES, WIDTH/2, derived number of 2-bit slices; not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = unsigned, 1 = signed two's complement; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse when results update.
- AgB  output  1  registered result, A > B.
- AlB  output  1  registered result, A < B.
- AeqB  output  1  registered result, A == B.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; busy, done, AgB, AlB, AeqB = 0; operand registers = 0; slice index = SLICES-1.
- States: IDLE and COMPARE.
- IDLE:
  - On a rising edge with start = 1: latch A, B and mode; index = SLICES-1; go to COMPARE; busy = 1.
  - If mode = 1, the MSB of each latched operand is inverted on capture (offset-binary), so the unsigned slice compare yields the signed order.
- COMPARE, each edge examines slice [2*index+1 : 2*index] of the latched operands:
  - slice A > slice B: AgB=1, AlB=0, AeqB=0, done=1, busy=0, go to IDLE.
  - slice A < slice B: AlB=1, AgB=0, AeqB=0, done=1, busy=0, go to IDLE.
  - slices equal and index = 0: AeqB=1, AgB=0, AlB=0, done=1, busy=0, go to IDLE.
  - slices equal and index > 0: decrement index, stay in COMPARE.
- Latency: start sampled at edge E0; the result and done appear after edge E0+k, where k = 1 + the number of leading equal slices (1..SLICES). Worst case is SLICES cycles.
- done is high for exactly one cycle.
- AgB/AlB/AeqB hold their last value until the next result edge. They are one-hot after the first completion; all zero only before the first completion following reset.
- start while busy = 1 is ignored; no queueing.
- Inputs A, B and mode may change freely during COMPARE without affecting the result.
- start high in the cycle done is high is accepted: back-to-back operation with no idle gap.
- start held high continuously restarts a new comparison every completion.
- Reset asserted mid-COMPARE aborts at once: outputs go to 0 and state returns to IDLE. The first start after reset deassertion is sampled normally.
- WIDTH = 2 degenerates to a single-cycle compare; busy is high for exactly one cycle.

Test Plan:
1. Assert rst, clocks running -> busy=done=AgB=AlB=AeqB=0. Deassert rst, start=0 for 5 cycles -> all outputs remain 0.
2. WIDTH=8, mode=0, A=8'hF3, B=8'hA3, start pulse -> done after 1 cycle, AgB=1, AlB=0, AeqB=0, busy high 1 cycle.
3. mode=0, A=8'h25, B=8'h27 -> slices equal for 3 cycles, done after 4th edge, AlB=1. Then A=B=8'h5A -> done after 4 cycles, AeqB=1.
4. A=8'hF0, B=8'h10: mode=1 -> done after 1 cycle, AlB=1. Same operands with mode=0 -> AgB=1.
5. Start A=8'h00, B=8'h01; one cycle later drive start=1 with A=8'hFF, B=8'h00 -> second start ignored, result AlB=1 after 4 cycles. Start on the done cycle -> accepted, second result valid with no gap.
6. Start A=B=8'h33, assert rst after 2 cycles -> outputs 0 immediately, no done pulse. Release rst, start A=8'h80, B=8'h7F, mode=0 -> AgB=1 after 1 cycle.

Source files
------------

// File: rtl/seq_mag_comparator.sv
// Iterative magnitude comparator: examines one 2-bit slice per clock, MSB first,
// and stops at the first unequal slice. Supports unsigned and two's-complement operands.
module seq_mag_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AgB,
  output logic             AlB,
  output logic             AeqB
);

  localparam int unsigned SLICES = WIDTH / 2;
  localparam int unsigned IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] TOP  = IW'(SLICES - 1);

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("seq_mag_comparator: WIDTH must be even and >= 2");
  end

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;

  always_comb begin
    slice_a = a_q[{idx, 1'b0} +: 2];
    slice_b = b_q[{idx, 1'b0} +: 2];
  end

  // Signed mode flips the sign bits on capture (offset binary), so the unsigned
  // slice compare orders two's-complement values correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= TOP;
      busy  <= 1'b0;
      done  <= 1'b0;
      AgB   <= 1'b0;
      AlB   <= 1'b0;
      AeqB  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= {A[WIDTH-1] ^ mode, A[WIDTH-2:0]};
            b_q   <= {B[WIDTH-1] ^ mode, B[WIDTH-2:0]};
            idx   <= TOP;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (slice_a > slice_b) begin
            AgB   <= 1'b1;
            AlB   <= 1'b0;
            AeqB  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (slice_a < slice_b) begin
            AgB   <= 1'b0;
            AlB   <= 1'b1;
            AeqB  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == '0) begin
            AgB   <= 1'b0;
            AlB   <= 1'b0;
            AeqB  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
